// File: rtl/div_clk_monitor.sv
// Edge/phase monitor for a divided clock that lives in the same clk domain.
// Emits edge strobes, measures high/low phase lengths, and reports lock/error/stall status.
module div_clk_monitor #(
  parameter int MEAS_W   = 18,
  parameter int EXP_HIGH = 32768,
  parameter int EXP_LOW  = 32768,
  parameter int TOL      = 2,
  parameter int LOCK_N   = 4,
  parameter int TIMEOUT  = 65600
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_div,
  input  logic              clr,
  output logic              rise_stb,
  output logic              fall_stb,
  output logic [MEAS_W-1:0] high_len,
  output logic [MEAS_W-1:0] low_len,
  output logic              lock,
  output logic              err_stb,
  output logic              stall,
  output logic [7:0]        err_cnt
);

  localparam logic [MEAS_W-1:0] CNT_MAX    = '1;
  localparam logic [31:0]       EXP_HIGH_U = 32'(EXP_HIGH);
  localparam logic [31:0]       EXP_LOW_U  = 32'(EXP_LOW);
  localparam logic [31:0]       TOL_U      = 32'(TOL);
  localparam logic [31:0]       TIMEOUT_U  = 32'(TIMEOUT);
  localparam logic [7:0]        LOCK_U     = 8'(LOCK_N);

  typedef enum logic [1:0] {SYNC, MEAS, STALL} state_t;

  state_t              state_q, state_d;
  logic                d1_q;
  logic [MEAS_W-1:0]   cnt_q, cnt_d;
  logic [7:0]          good_cnt_q, good_cnt_d;
  logic                hi_ok_q, hi_ok_d;
  logic                rise_stb_q, fall_stb_q;
  logic [MEAS_W-1:0]   high_len_q, high_len_d;
  logic [MEAS_W-1:0]   low_len_q, low_len_d;
  logic                lock_q, lock_d;
  logic                err_stb_q, err_stb_d;
  logic                stall_q, stall_d;
  logic [7:0]          err_cnt_q, err_cnt_d;

  logic div_edge, div_rise, div_fall;
  logic hi_ok_now, lo_ok_now;

  assign div_edge = clk_div ^ d1_q;
  assign div_rise = clk_div & ~d1_q;
  assign div_fall = ~clk_div & d1_q;

  // A saturated counter never passes, whatever the tolerance window says.
  function automatic logic phase_ok(input logic [MEAS_W-1:0] len, input logic [31:0] expv);
    logic [31:0] l32;
    logic [31:0] diff;
    l32  = 32'(len);
    diff = (l32 > expv) ? (l32 - expv) : (expv - l32);
    return (len != CNT_MAX) && (diff <= TOL_U);
  endfunction

  assign hi_ok_now = phase_ok(cnt_q, EXP_HIGH_U);
  assign lo_ok_now = phase_ok(cnt_q, EXP_LOW_U);

  always_comb begin
    state_d    = state_q;
    hi_ok_d    = hi_ok_q;
    good_cnt_d = good_cnt_q;
    lock_d     = lock_q;
    stall_d    = stall_q;
    high_len_d = high_len_q;
    low_len_d  = low_len_q;
    err_stb_d  = 1'b0;
    if (div_edge)
      cnt_d = MEAS_W'(1);
    else if (cnt_q == CNT_MAX)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + MEAS_W'(1);

    case (state_q)
      SYNC: begin
        if (div_edge) begin
          state_d = MEAS;
          hi_ok_d = 1'b0;
        end
      end
      MEAS: begin
        if (div_fall) begin
          high_len_d = cnt_q;
          hi_ok_d    = hi_ok_now;
          if (!hi_ok_now) begin
            err_stb_d  = 1'b1;
            good_cnt_d = '0;
            lock_d     = 1'b0;
          end
        end else if (div_rise) begin
          low_len_d = cnt_q;
          if (lo_ok_now && hi_ok_q) begin
            good_cnt_d = (good_cnt_q == 8'hFF) ? good_cnt_q : good_cnt_q + 8'd1;
            if (good_cnt_d >= LOCK_U)
              lock_d = 1'b1;
          end else begin
            good_cnt_d = '0;
            lock_d     = 1'b0;
            err_stb_d  = ~lo_ok_now;
          end
        end else if (32'(cnt_q) >= TIMEOUT_U) begin
          state_d    = STALL;
          stall_d    = 1'b1;
          err_stb_d  = 1'b1;
          lock_d     = 1'b0;
          good_cnt_d = '0;
          hi_ok_d    = 1'b0;
        end
      end
      STALL: begin
        // The edge that ends a stall only re-synchronises; its phase is meaningless.
        if (div_edge) begin
          stall_d = 1'b0;
          state_d = MEAS;
          hi_ok_d = 1'b0;
        end
      end
      default: state_d = SYNC;
    endcase

    err_cnt_d = (err_stb_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SYNC;
      d1_q       <= 1'b0;
      cnt_q      <= '0;
      good_cnt_q <= '0;
      hi_ok_q    <= 1'b0;
      rise_stb_q <= 1'b0;
      fall_stb_q <= 1'b0;
      high_len_q <= '0;
      low_len_q  <= '0;
      lock_q     <= 1'b0;
      err_stb_q  <= 1'b0;
      stall_q    <= 1'b0;
      err_cnt_q  <= '0;
    end else if (clr) begin
      state_q    <= SYNC;
      d1_q       <= clk_div;
      cnt_q      <= '0;
      good_cnt_q <= '0;
      hi_ok_q    <= 1'b0;
      rise_stb_q <= 1'b0;
      fall_stb_q <= 1'b0;
      high_len_q <= '0;
      low_len_q  <= '0;
      lock_q     <= 1'b0;
      err_stb_q  <= 1'b0;
      stall_q    <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      d1_q       <= clk_div;
      cnt_q      <= cnt_d;
      good_cnt_q <= good_cnt_d;
      hi_ok_q    <= hi_ok_d;
      rise_stb_q <= div_rise;
      fall_stb_q <= div_fall;
      high_len_q <= high_len_d;
      low_len_q  <= low_len_d;
      lock_q     <= lock_d;
      err_stb_q  <= err_stb_d;
      stall_q    <= stall_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign rise_stb = rise_stb_q;
  assign fall_stb = fall_stb_q;
  assign high_len = high_len_q;
  assign low_len  = low_len_q;
  assign lock     = lock_q;
  assign err_stb  = err_stb_q;
  assign stall    = stall_q;
  assign err_cnt  = err_cnt_q;

endmodule
